parity_check_stage: RTL and testbench
=====================================

PARITY_CHECK_STAGE -- requirements
Module: parity_check_stage

Interface
REQ-001 Parameter DATA_WIDTH, 17, FIFO element width; MSB is the parity bit, bits [DATA_WIDTH-2:0] are payload; the value SHALL be legal from 2 upward.
REQ-002 Parameter CNT_WIDTH, 8, error counter width; the value SHALL be legal from 1 upward.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 fifo_data  input  DATA_WIDTH  element from the FIFO data output.
REQ-006 fifo_valid  input  1  FIFO output valid.
REQ-007 fifo_grant  output  1  drives the FIFO grant input; high = stage accepts a beat this cycle.
REQ-008 dout  output  DATA_WIDTH-1  checked payload.
REQ-009 dout_valid  output  1  dout, dout_err are valid.
REQ-010 dout_grant  input  1  downstream consumer accepts.
REQ-011 dout_err  output  1  sideband; high = this beat failed parity.
REQ-012 err_count  output  CNT_WIDTH  count of parity errors, saturating.
REQ-013 err_sticky  output  1  set on the first error; held until cleared.
REQ-014 clr_err  input  1  synchronous clear of err_count and err_sticky.

Function
REQ-015 An input transfer SHALL occur when fifo_valid and fifo_grant are high in the same cycle; an output transfer SHALL occur when dout_valid and dout_grant are high in the same cycle.
REQ-016 A beat SHALL be good when the XOR of all DATA_WIDTH bits of fifo_data is 0 (even parity); otherwise it is a parity error.
REQ-017 Buffering SHALL be a 2-entry skid buffer (main register drives dout, skid register behind it) with FSM states EMPTY, ONE, TWO.
REQ-018 fifo_grant SHALL be a registered output, high in EMPTY and ONE and low in TWO; it SHALL NOT combinationally depend on dout_grant.
REQ-019 Transitions: EMPTY+in -> ONE; ONE+in+!out -> TWO; ONE+!in+out -> EMPTY; ONE+in+out -> ONE; TWO+out -> ONE, skid moves to main; all other combinations SHALL hold state.
REQ-020 Latency SHALL be 1 cycle: a beat accepted in EMPTY appears on dout, with dout_valid high, in the next cycle.
REQ-021 dout, dout_valid and dout_err SHALL remain stable while dout_valid is high and dout_grant is low.
REQ-022 Beats SHALL leave in acceptance order; none SHALL be lost or duplicated.
REQ-023 Each accepted erroneous beat SHALL increment err_count by 1, saturating at 2^CNT_WIDTH-1, and SHALL set err_sticky, both effective in the cycle after acceptance.
REQ-024 If clr_err and an error acceptance occur in the same cycle, the next values SHALL be err_count=1 and err_sticky=1; clr_err alone SHALL give 0 and 0.
REQ-025 fifo_valid SHALL be ignored while fifo_grant is low.

Reset
REQ-026 When rst_n is low at a clock edge, the next values SHALL be: state EMPTY, dout_valid 0, dout 0, dout_err 0, err_count 0, err_sticky 0, fifo_grant 0.
REQ-027 fifo_grant SHALL rise in the first cycle after rst_n is sampled high.
REQ-028 Reset mid-operation SHALL discard all buffered beats and take priority over every transfer and clr_err.

Configuration
REQ-029 The macro PARITY_DROP_EN SHALL control handling of erroneous beats.
REQ-030 With PARITY_DROP_EN defined, an erroneous beat SHALL still be accepted and counted but SHALL NOT enter the buffer, and dout_err SHALL be tied to 0.
REQ-031 Without PARITY_DROP_EN, an erroneous beat SHALL be forwarded like a good beat, with dout_err=1.

Verification
REQ-032 Reset, then fifo_data=17'h0_0003 valid, dout_grant=1 -> next cycle dout=16'h0003, dout_valid=1, dout_err=0, err_count=0.
REQ-033 dout_grant=0, three beats offered back-to-back -> fifo_grant low after 2 acceptances; raise dout_grant -> all 3 beats emerge in order, no gaps after the first.
REQ-034 fifo_data=17'h0_0001 (bad parity): without the macro, dout_err=1 and err_count=1; with PARITY_DROP_EN, dout_valid stays 0 and err_count=1.
REQ-035 CNT_WIDTH=2, 5 bad beats -> err_count saturates at 3 and err_sticky=1; clr_err together with a 6th bad beat -> err_count=1.
REQ-036 Assert rst_n=0 in state TWO -> next cycle dout_valid=0, fifo_grant=0, err_count=0; after release, the buffered beats are never output.

Source files
------------

// File: rtl/parity_check_stage_if.sv
// Stream bundle for parity_check_stage: FIFO-side input handshake plus the checked output stream.
// slave = the stage itself, master = the environment driving it.
interface parity_check_stage_if #(
    parameter int unsigned DATA_WIDTH = 17
);
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_valid;
    logic                  fifo_grant;
    logic [DATA_WIDTH-2:0] dout;
    logic                  dout_valid;
    logic                  dout_grant;
    logic                  dout_err;

    modport master (
        output fifo_data, fifo_valid, dout_grant,
        input  fifo_grant, dout, dout_valid, dout_err
    );

    modport slave (
        input  fifo_data, fifo_valid, dout_grant,
        output fifo_grant, dout, dout_valid, dout_err
    );
endinterface

// File: rtl/parity_check_stage.sv
// Even-parity check stage behind a FIFO: 2-entry skid buffer, saturating error counter, sticky flag.
// Define PARITY_DROP_EN to count erroneous beats without forwarding them.
module parity_check_stage #(
    parameter int unsigned DATA_WIDTH = 17,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parity_check_stage_if.slave  bus,
    input  logic                 clr_err,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic                 err_sticky
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                state;
    logic [DATA_WIDTH-2:0] main_data;
    logic [DATA_WIDTH-2:0] skid_data;
    logic                  main_err;
    logic                  skid_err;
    logic                  beat_bad;
    logic                  beat_err;
    logic                  in_xfer;
    logic                  in_buf;
    logic                  out_xfer;
    logic                  err_acc;

    assign beat_bad = ^bus.fifo_data;
    assign in_xfer  = bus.fifo_valid & bus.fifo_grant;
    assign out_xfer = bus.dout_valid & bus.dout_grant;
    assign err_acc  = in_xfer & beat_bad;

`ifdef PARITY_DROP_EN
    // Bad beats are consumed from the FIFO but never buffered, so the stored error bit stays 0.
    assign in_buf   = in_xfer & ~beat_bad;
    assign beat_err = 1'b0;
`else
    assign in_buf   = in_xfer;
    assign beat_err = beat_bad;
`endif

    assign bus.dout     = main_data;
    assign bus.dout_err = main_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= EMPTY;
            main_data      <= '0;
            main_err       <= 1'b0;
            skid_data      <= '0;
            skid_err       <= 1'b0;
            bus.dout_valid <= 1'b0;
            bus.fifo_grant <= 1'b0;
        end else begin
            // Grant is registered: it mirrors "next state is not TWO".
            bus.fifo_grant <= 1'b1;
            case (state)
                EMPTY: begin
                    if (in_buf) begin
                        main_data      <= bus.fifo_data[DATA_WIDTH-2:0];
                        main_err       <= beat_err;
                        bus.dout_valid <= 1'b1;
                        state          <= ONE;
                    end
                end
                ONE: begin
                    if (in_buf && !out_xfer) begin
                        skid_data      <= bus.fifo_data[DATA_WIDTH-2:0];
                        skid_err       <= beat_err;
                        bus.fifo_grant <= 1'b0;
                        state          <= TWO;
                    end else if (in_buf && out_xfer) begin
                        main_data <= bus.fifo_data[DATA_WIDTH-2:0];
                        main_err  <= beat_err;
                    end else if (out_xfer) begin
                        bus.dout_valid <= 1'b0;
                        state          <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_data <= skid_data;
                        main_err  <= skid_err;
                        state     <= ONE;
                    end else begin
                        bus.fifo_grant <= 1'b0;
                    end
                end
                default: begin
                    bus.dout_valid <= 1'b0;
                    state          <= EMPTY;
                end
            endcase
        end
    end

    // A clear coinciding with an error acceptance leaves exactly that one error recorded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (clr_err) begin
            err_count  <= err_acc ? CNT_ONE : '0;
            err_sticky <= err_acc;
        end else if (err_acc) begin
            if (err_count != CNT_MAX) begin
                err_count <= err_count + CNT_ONE;
            end
            err_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_parity_check_stage.sv
// Directed self-checking bench for parity_check_stage (CNT_WIDTH=2 to reach saturation quickly).
// Honours PARITY_DROP_EN when defined for the build.
module tb_parity_check_stage;
    localparam int unsigned DW = 17;
    localparam int unsigned CW = 2;

    logic          clk;
    logic          rst_n;
    logic          clr_err;
    logic [CW-1:0] err_count;
    logic          err_sticky;

    int unsigned n_checks;
    int unsigned n_pass;

    parity_check_stage_if #(.DATA_WIDTH(DW)) bus ();

    parity_check_stage #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_err   (clr_err),
        .err_count (err_count),
        .err_sticky(err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        rst_n           = 1'b0;
        clr_err         = 1'b0;
        bus.fifo_data   = '0;
        bus.fifo_valid  = 1'b0;
        bus.dout_grant  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        check("rst_fifo_grant", 32'(bus.fifo_grant), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_err_sticky", 32'(err_sticky), 32'd0);
        rst_n = 1'b1;
        tick();
        check("grant_after_rst", 32'(bus.fifo_grant), 32'd1);
        check("empty_after_rst", 32'(bus.dout_valid), 32'd0);

        // Single good beat, 1-cycle latency
        bus.fifo_data  = 17'h0_0003;
        bus.fifo_valid = 1'b1;
        bus.dout_grant = 1'b1;
        tick();
        check("lat_dout", 32'(bus.dout), 32'h0003);
        check("lat_valid", 32'(bus.dout_valid), 32'd1);
        check("lat_err", 32'(bus.dout_err), 32'd0);
        check("lat_count", 32'(err_count), 32'd0);
        bus.fifo_valid = 1'b0;
        tick();
        check("lat_drain", 32'(bus.dout_valid), 32'd0);

        // Backpressure: fill both entries, third beat must wait
        bus.dout_grant = 1'b0;
        bus.fifo_valid = 1'b1;
        bus.fifo_data  = 17'h0_0005;
        tick();
        check("bp_grant_one", 32'(bus.fifo_grant), 32'd1);
        bus.fifo_data = 17'h0_0006;
        tick();
        check("bp_grant_two", 32'(bus.fifo_grant), 32'd0);
        check("bp_head", 32'(bus.dout), 32'h0005);
        bus.fifo_data = 17'h0_000F;
        tick();
        check("bp_hold_dout", 32'(bus.dout), 32'h0005);
        check("bp_hold_valid", 32'(bus.dout_valid), 32'd1);
        check("bp_hold_grant", 32'(bus.fifo_grant), 32'd0);
        bus.dout_grant = 1'b1;
        tick();
        check("bp_out2", 32'(bus.dout), 32'h0006);
        check("bp_out2_valid", 32'(bus.dout_valid), 32'd1);
        tick();
        check("bp_out3", 32'(bus.dout), 32'h000F);
        check("bp_out3_valid", 32'(bus.dout_valid), 32'd1);
        bus.fifo_valid = 1'b0;
        tick();
        check("bp_drain", 32'(bus.dout_valid), 32'd0);

        // Single bad-parity beat
        bus.fifo_data  = 17'h0_0001;
        bus.fifo_valid = 1'b1;
        tick();
`ifdef PARITY_DROP_EN
        check("bad_dropped", 32'(bus.dout_valid), 32'd0);
`else
        check("bad_valid", 32'(bus.dout_valid), 32'd1);
        check("bad_dout", 32'(bus.dout), 32'h0001);
        check("bad_err", 32'(bus.dout_err), 32'd1);
`endif
        check("bad_count", 32'(err_count), 32'd1);
        check("bad_sticky", 32'(err_sticky), 32'd1);
        bus.fifo_valid = 1'b0;
        tick();

        // Parity bit set, payload excludes it
        bus.fifo_data  = 17'h1_0001;
        bus.fifo_valid = 1'b1;
        tick();
        check("msb_dout", 32'(bus.dout), 32'h0001);
        check("msb_err", 32'(bus.dout_err), 32'd0);
        check("msb_count", 32'(err_count), 32'd1);

        // Saturation: four more bad beats back-to-back
        bus.fifo_data = 17'h0_0002;
        tick();
        check("sat_c2", 32'(err_count), 32'd2);
`ifndef PARITY_DROP_EN
        check("sat_err_fwd", 32'(bus.dout_err), 32'd1);
`endif
        bus.fifo_data = 17'h0_0004;
        tick();
        check("sat_c3", 32'(err_count), 32'd3);
        bus.fifo_data = 17'h0_0007;
        tick();
        check("sat_hold_a", 32'(err_count), 32'd3);
        bus.fifo_data = 17'h1_0000;
        tick();
        check("sat_hold_b", 32'(err_count), 32'd3);
        check("sat_sticky", 32'(err_sticky), 32'd1);

        // Clear together with a 6th bad beat, then clear alone
        bus.fifo_data = 17'h0_0008;
        clr_err       = 1'b1;
        tick();
        check("clr_err_count", 32'(err_count), 32'd1);
        check("clr_err_sticky", 32'(err_sticky), 32'd1);
        bus.fifo_valid = 1'b0;
        tick();
        check("clr_only_count", 32'(err_count), 32'd0);
        check("clr_only_sticky", 32'(err_sticky), 32'd0);
        clr_err = 1'b0;
        tick();
        check("clr_drain", 32'(bus.dout_valid), 32'd0);

        // Fill to TWO, then reset discards everything
        bus.dout_grant = 1'b0;
        bus.fifo_valid = 1'b1;
        bus.fifo_data  = 17'h0_0001;
        tick();
        bus.fifo_data = 17'h0_0003;
        tick();
        bus.fifo_data = 17'h0_0005;
        tick();
        check("two_grant", 32'(bus.fifo_grant), 32'd0);
        check("two_valid", 32'(bus.dout_valid), 32'd1);
        check("two_count", 32'(err_count), 32'd1);
        bus.fifo_valid = 1'b0;
        rst_n          = 1'b0;
        tick();
        check("mid_rst_valid", 32'(bus.dout_valid), 32'd0);
        check("mid_rst_grant", 32'(bus.fifo_grant), 32'd0);
        check("mid_rst_count", 32'(err_count), 32'd0);
        check("mid_rst_dout", 32'(bus.dout), 32'd0);
        rst_n          = 1'b1;
        bus.dout_grant = 1'b1;
        tick();
        check("post_rst_grant", 32'(bus.fifo_grant), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_no_beat", 32'(bus.dout_valid), 32'd0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
